// File: rtl/button_press_classifier.sv
// Button gesture classifier: short, double, long and auto-repeat pulses
// from a debounced active-high button level.
module button_press_classifier #(
    parameter int unsigned CLK_PERIOD_NS = 10,
    parameter int unsigned LONG_PRESS_MS = 800,
    parameter int unsigned DOUBLE_GAP_MS = 250,
    parameter int unsigned REPEAT_MS     = 150
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clean_in,
    output logic short_out,
    output logic double_out,
    output logic long_out,
    output logic repeat_out,
    output logic held_out,
    output logic busy_out
);

    localparam logic [63:0] PER    = 64'(CLK_PERIOD_NS);
    localparam logic [63:0] NS_MS  = 64'd1_000_000;
    localparam logic [63:0] LONG_L = (64'(LONG_PRESS_MS) * NS_MS + PER - 64'd1) / PER;
    localparam logic [63:0] GAP_L  = (64'(DOUBLE_GAP_MS) * NS_MS + PER - 64'd1) / PER;
    localparam logic [63:0] REP_L  = (64'(REPEAT_MS) * NS_MS + PER - 64'd1) / PER;

    localparam int LONG_CYC   = int'(LONG_L);
    localparam int GAP_CYC    = int'(GAP_L);
    localparam int REPEAT_CYC = int'(REP_L);

    localparam int MAX_A   = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_A > REPEAT_CYC) ? MAX_A : REPEAT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    if (LONG_CYC < 2 || GAP_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_timing
        $error("button_press_classifier: derived cycle counts must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        LONG_HOLD,
        WAIT_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             rise;

    assign rise = clean_in & ~clean_q;

    // Gesture FSM: next state, counter and pulse decisions
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                if (!clean_in) begin
                    state_d = WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT2: begin
                if (rise) begin
                    double_d = 1'b1;
                    state_d  = WAIT_REL;
                    cnt_d    = '0;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LONG_HOLD: begin
                if (!clean_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                if (!clean_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, edge history and registered pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            clean_q  <= 1'b1;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            clean_q  <= clean_in;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign short_out  = short_q;
    assign double_out = double_q;
    assign long_out   = long_q;
    assign repeat_out = repeat_q;
    assign held_out   = (state_q == LONG_HOLD);
    assign busy_out   = (state_q != IDLE);

endmodule
